// File: rtl/rc4_key_search_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rc4_key_search_ctrl                                                        |
// | Sequences init/shuffle/decrypt per candidate key, muxes the S-RAM write    |
// | port and scans the decrypted message for printable text.                   |
// | Optional: RC4_KEY_SEARCH_TIMEOUT_EN adds a per-phase watchdog.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rc4_key_search_ctrl #(
  parameter int                   KEY_WIDTH      = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START      = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_END        = 24'h3FFFFF,
  parameter int                   MSG_DEP        = 32,
  parameter int                   TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  output logic [KEY_WIDTH-1:0]       key,
  output logic                       init_start,
  output logic                       shuf_start,
  output logic                       dec_start,
  input  logic                       init_done,
  input  logic                       shuf_done,
  input  logic                       dec_done,
  input  logic [7:0]                 init_addr,
  input  logic [7:0]                 init_wdata,
  input  logic                       init_wren,
  input  logic [7:0]                 shuf_addr,
  input  logic [7:0]                 shuf_wdata,
  input  logic                       shuf_wren,
  input  logic [7:0]                 dec_addr,
  input  logic [7:0]                 dec_wdata,
  input  logic                       dec_wren,
  output logic [7:0]                 s_addr,
  output logic [7:0]                 s_wdata,
  output logic                       s_wren,
  output logic [$clog2(MSG_DEP)-1:0] dmsg_addr,
  input  logic [7:0]                 dmsg_data,
  output logic                       busy,
  output logic                       found,
  output logic                       fail,
  output logic                       timeout_err
);

  localparam int c_K_W = $clog2(MSG_DEP);
  localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(MSG_DEP - 1);

  localparam logic [3:0] c_ST_IDLE       = 4'd0;
  localparam logic [3:0] c_ST_START_INIT = 4'd1;
  localparam logic [3:0] c_ST_WAIT_INIT  = 4'd2;
  localparam logic [3:0] c_ST_START_SHUF = 4'd3;
  localparam logic [3:0] c_ST_WAIT_SHUF  = 4'd4;
  localparam logic [3:0] c_ST_START_DEC  = 4'd5;
  localparam logic [3:0] c_ST_WAIT_DEC   = 4'd6;
  localparam logic [3:0] c_ST_CHECK_RD   = 4'd7;
  localparam logic [3:0] c_ST_CHECK_CMP  = 4'd8;
  localparam logic [3:0] c_ST_NEXT_KEY   = 4'd9;
  localparam logic [3:0] c_ST_FOUND      = 4'd10;
  localparam logic [3:0] c_ST_FAIL       = 4'd11;

  logic [3:0]           r_state;
  logic [3:0]           w_next_state;
  logic [KEY_WIDTH-1:0] r_key;
  logic [c_K_W-1:0]     r_k;
  logic                 w_idle_like;
  logic                 w_printable;
  logic                 w_last_byte;
  logic                 w_wdog_expired;

  assign w_idle_like = (r_state == c_ST_IDLE) || (r_state == c_ST_FOUND) ||
                       (r_state == c_ST_FAIL);
  assign w_printable = ((dmsg_data >= 8'h61) && (dmsg_data <= 8'h7A)) ||
                       (dmsg_data == 8'h20);
  assign w_last_byte = (r_k == c_K_LAST);

`ifdef RC4_KEY_SEARCH_TIMEOUT_EN
  localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [c_WDOG_W-1:0] r_wdog;
  logic                r_timeout_err;
  logic                w_in_wait;
  logic                w_phase_done;

  assign w_in_wait = (r_state == c_ST_WAIT_INIT) || (r_state == c_ST_WAIT_SHUF) ||
                     (r_state == c_ST_WAIT_DEC);
  assign w_phase_done = ((r_state == c_ST_WAIT_INIT) && init_done) ||
                        ((r_state == c_ST_WAIT_SHUF) && shuf_done) ||
                        ((r_state == c_ST_WAIT_DEC)  && dec_done);
  assign w_wdog_expired = (r_wdog == c_WDOG_LAST);
  assign timeout_err    = r_timeout_err;

  // Counter is held at zero outside WAIT states, so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wdog <= w_in_wait ? r_wdog + 1'b1 : '0;
      if (w_idle_like && go)
        r_timeout_err <= 1'b0;
      else if (w_in_wait && !w_phase_done && w_wdog_expired)
        r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_wdog_expired = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_FOUND, c_ST_FAIL:
        if (go) w_next_state = c_ST_START_INIT;
      c_ST_START_INIT: w_next_state = c_ST_WAIT_INIT;
      c_ST_WAIT_INIT:
        if (init_done)           w_next_state = c_ST_START_SHUF;
        else if (w_wdog_expired) w_next_state = c_ST_FAIL;
      c_ST_START_SHUF: w_next_state = c_ST_WAIT_SHUF;
      c_ST_WAIT_SHUF:
        if (shuf_done)           w_next_state = c_ST_START_DEC;
        else if (w_wdog_expired) w_next_state = c_ST_FAIL;
      c_ST_START_DEC:  w_next_state = c_ST_WAIT_DEC;
      c_ST_WAIT_DEC:
        if (dec_done)            w_next_state = c_ST_CHECK_RD;
        else if (w_wdog_expired) w_next_state = c_ST_FAIL;
      c_ST_CHECK_RD:   w_next_state = c_ST_CHECK_CMP;
      c_ST_CHECK_CMP:
        if (!w_printable)        w_next_state = c_ST_NEXT_KEY;
        else if (w_last_byte)    w_next_state = c_ST_FOUND;
        else                     w_next_state = c_ST_CHECK_RD;
      c_ST_NEXT_KEY:
        w_next_state = (r_key == KEY_END) ? c_ST_FAIL : c_ST_START_INIT;
      default:         w_next_state = c_ST_IDLE;
    endcase
  end

  // Key range check is plain equality, so a KEY_END below KEY_START wraps the key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key <= '0;
      r_k   <= '0;
    end else begin
      if (w_idle_like && go)
        r_key <= KEY_START;
      else if ((r_state == c_ST_NEXT_KEY) && (r_key != KEY_END))
        r_key <= r_key + 1'b1;
      if ((r_state == c_ST_WAIT_DEC) && dec_done)
        r_k <= '0;
      else if ((r_state == c_ST_CHECK_CMP) && w_printable && !w_last_byte)
        r_k <= r_k + 1'b1;
    end
  end

  always_comb begin
    init_start = (r_state == c_ST_START_INIT);
    shuf_start = (r_state == c_ST_START_SHUF);
    dec_start  = (r_state == c_ST_START_DEC);
    busy       = !w_idle_like;
    found      = (r_state == c_ST_FOUND);
    fail       = (r_state == c_ST_FAIL);
    s_addr     = 8'h00;
    s_wdata    = 8'h00;
    s_wren     = 1'b0;
    case (r_state)
      c_ST_START_INIT, c_ST_WAIT_INIT: begin
        s_addr  = init_addr;
        s_wdata = init_wdata;
        s_wren  = init_wren;
      end
      c_ST_START_SHUF, c_ST_WAIT_SHUF: begin
        s_addr  = shuf_addr;
        s_wdata = shuf_wdata;
        s_wren  = shuf_wren;
      end
      c_ST_START_DEC, c_ST_WAIT_DEC: begin
        s_addr  = dec_addr;
        s_wdata = dec_wdata;
        s_wren  = dec_wren;
      end
      default: ;
    endcase
  end

  assign key       = r_key;
  assign dmsg_addr = r_k;

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rc4_key_search_ctrl                                                     |
// | Bench for rc4_key_search_ctrl with emulated phase units and message RAM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rc4_key_search_ctrl;

  localparam int          KW = 24;
  localparam logic [23:0] KS = 24'h000005;
  localparam logic [23:0] KE = 24'h000007;
  localparam int          MD = 32;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [23:0] key;
  logic        init_start, shuf_start, dec_start;
  logic        init_done = 1'b0, shuf_done = 1'b0, dec_done = 1'b0;
  logic [7:0]  init_addr = 8'h0, init_wdata = 8'h0, shuf_addr = 8'h0, shuf_wdata = 8'h0;
  logic [7:0]  dec_addr = 8'h0, dec_wdata = 8'h0;
  logic        init_wren = 1'b0, shuf_wren = 1'b0, dec_wren = 1'b0;
  logic [7:0]  s_addr, s_wdata;
  logic        s_wren;
  logic [4:0]  dmsg_addr;
  logic [7:0]  dmsg_data = 8'h0;
  logic        busy, found, fail, timeout_err;

  always #5 clk = ~clk;

  rc4_key_search_ctrl #(
    .KEY_WIDTH(KW), .KEY_START(KS), .KEY_END(KE), .MSG_DEP(MD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .key(key),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done),
    .init_addr(init_addr), .init_wdata(init_wdata), .init_wren(init_wren),
    .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata), .shuf_wren(shuf_wren),
    .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren),
    .dmsg_addr(dmsg_addr), .dmsg_data(dmsg_data),
    .busy(busy), .found(found), .fail(fail), .timeout_err(timeout_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  msg [0:7][0:MD-1];
  int          owner = 0;
  int          cnt [1:3];
  bit          done_v [1:3];
  int          n_start [1:3];
  int          wait_sum, busy_cycles, fixed_lat;
  bit          noise_en = 1'b0, hang_dec = 1'b0, go_req = 1'b0, rst_req = 1'b1;
  bit          first_seen;
  logic [23:0] first_key;
  logic [7:0]  pend = 8'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit printable(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  function automatic logic [7:0] rnd_print();
    int r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rnd_bad();
    logic [7:0] b;
    case ($urandom_range(0, 4))
      0: b = 8'h60;
      1: b = 8'h7B;
      2: b = 8'h1F;
      3: b = 8'h21;
      default: begin
        b = 8'($urandom);
        while (printable(b)) b = 8'($urandom);
      end
    endcase
    return b;
  endfunction

  // bad < 0 means every byte printable; otherwise the first non-printable byte is at bad.
  task automatic fill(input int k, input int bad);
    for (int i = 0; i < MD; i++) begin
      if (bad < 0 || i < bad) msg[k][i] = rnd_print();
      else if (i == bad)      msg[k][i] = rnd_bad();
      else                    msg[k][i] = 8'($urandom);
    end
  endtask

  task automatic tick();
    int lat;
    @(negedge clk);
    if (reset) begin
      owner = 0;
      for (int u = 1; u <= 3; u++) cnt[u] = 0;
    end
    reset = rst_req;
    if (!busy) owner = 0;
    if (busy) busy_cycles++;
    dmsg_data = pend;
    pend      = msg[key[2:0]][dmsg_addr];
    for (int u = 1; u <= 3; u++) begin
      done_v[u] = 1'b0;
      if (cnt[u] > 0) begin
        cnt[u]--;
        if (cnt[u] == 0) done_v[u] = 1'b1;
      end
    end
    for (int u = 1; u <= 3; u++) begin
      if ((u == 1 && init_start) || (u == 2 && shuf_start) || (u == 3 && dec_start)) begin
        owner = u;
        n_start[u]++;
        if (u == 1 && !first_seen) begin
          first_seen = 1'b1;
          first_key  = key;
        end
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        if (!(u == 3 && hang_dec)) begin
          cnt[u]   = lat;
          wait_sum += lat;
        end
      end
    end
    for (int u = 1; u <= 3; u++)
      if (noise_en && owner != u && cnt[u] == 0 && !done_v[u])
        done_v[u] = ($urandom_range(0, 3) == 0);
    init_done = done_v[1];
    shuf_done = done_v[2];
    dec_done  = done_v[3];
    go = go_req | (noise_en & busy & 1'($urandom_range(0, 1)));
    {init_wren, init_addr, init_wdata} = 17'($urandom);
    {shuf_wren, shuf_addr, shuf_wdata} = 17'($urandom);
    {dec_wren,  dec_addr,  dec_wdata}  = 17'($urandom);
    #1;
    case (owner)
      1:       chk("s_mux", {s_wren, s_addr, s_wdata}, {init_wren, init_addr, init_wdata});
      2:       chk("s_mux", {s_wren, s_addr, s_wdata}, {shuf_wren, shuf_addr, shuf_wdata});
      3:       chk("s_mux", {s_wren, s_addr, s_wdata}, {dec_wren, dec_addr, dec_wdata});
      default: chk("s_mux", {s_wren, s_addr, s_wdata}, 17'h0);
    endcase
    if (owner != 0 && done_v[owner]) owner = 0;
  endtask

  task automatic clear_stats();
    for (int u = 1; u <= 3; u++) n_start[u] = 0;
    wait_sum    = 0;
    busy_cycles = 0;
    first_seen  = 1'b0;
  endtask

  task automatic run_search();
    bit ended = 1'b0;
    clear_stats();
    go_req = 1'b1;
    tick();
    go_req = 1'b0;
    for (int i = 0; i < 5000 && !ended; i++) begin
      tick();
      ended = found | fail;
    end
    chk("search_ended", ended, 1'b1);
  endtask

  // Walks the key range over the message table and predicts result and cost.
  task automatic expect_model(input string tag);
    int          keys = 0, bytes = 0, nexts = 0, pos;
    bit          ef = 1'b0;
    logic [23:0] ek = KE;
    for (int k = int'(KS); k <= int'(KE) && !ef; k++) begin
      keys++;
      pos = -1;
      for (int i = 0; i < MD && pos < 0; i++)
        if (!printable(msg[k][i])) pos = i;
      if (pos < 0) begin
        bytes += MD;
        ef = 1'b1;
        ek = 24'(k);
      end else begin
        bytes += pos + 1;
        nexts++;
      end
    end
    chk({tag, ".found"}, found, ef);
    chk({tag, ".fail"}, fail, !ef);
    chk({tag, ".key"}, key, ek);
    chk({tag, ".n_init"}, n_start[1], keys);
    chk({tag, ".n_shuf"}, n_start[2], keys);
    chk({tag, ".n_dec"}, n_start[3], keys);
    chk({tag, ".first_key"}, first_key, KS);
    chk({tag, ".busy_cycles"}, busy_cycles, 3 * keys + wait_sum + 2 * bytes + nexts);
    chk({tag, ".timeout_err"}, timeout_err, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".found"}, found, 1'b0);
    chk({tag, ".fail"}, fail, 1'b0);
    chk({tag, ".timeout_err"}, timeout_err, 1'b0);
    chk({tag, ".key"}, key, 24'h0);
    chk({tag, ".starts"}, {init_start, shuf_start, dec_start}, 3'b000);
    chk({tag, ".dmsg_addr"}, dmsg_addr, 5'h0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < MD; i++) msg[k][i] = 8'h61;
    for (int u = 1; u <= 3; u++) cnt[u] = 0;
    clear_stats();
    fixed_lat = 3;

    repeat (3) tick();
    rst_req = 1'b0;
    tick();
    chk_reset_outputs("reset");

    // All bytes 8'h61, three-cycle units: first key wins.
    run_search();
    expect_model("all_a");
    chk("all_a.key_is_start", key, KS);
    chk("all_a.busy_cycles_exact", busy_cycles, 76);
    repeat (3) tick();
    chk("found_sticky", found, 1'b1);
    chk("found_key_hold", key, KS);

    fixed_lat = 0;
    noise_en  = 1'b1;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < MD; i++) msg[k][i] = 8'hFF;
    run_search();
    expect_model("all_ff");
    chk("all_ff.key_end", key, KE);

    fill(5, 31);
    fill(6, -1);
    fill(7, 0);
    run_search();
    expect_model("last_byte_bad");

    for (int r = 0; r < 4; r++) begin
      for (int k = 5; k <= 7; k++)
        fill(k, ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, MD - 1)));
      run_search();
      expect_model("random");
    end

    // Reset while the shuffle unit is still working.
    fixed_lat = 6;
    clear_stats();
    go_req = 1'b1;
    tick();
    go_req = 1'b0;
    for (int i = 0; i < 200 && !(owner == 2 && !shuf_start); i++) tick();
    chk("reached_wait_shuf", owner, 2);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    chk_reset_outputs("mid_reset");
    tick();
    chk("mid_reset.idle_hold", busy, 1'b0);
    fixed_lat = 0;
    fill(5, 3);
    fill(6, -1);
    fill(7, -1);
    run_search();
    expect_model("restart");

    // Decrypt unit never answers.
    noise_en = 1'b0;
    hang_dec = 1'b1;
    clear_stats();
    go_req = 1'b1;
    tick();
    go_req = 1'b0;
    for (int i = 0; i < 200 && n_start[3] == 0; i++) tick();
    chk("hang.dec_started", n_start[3], 1);
`ifdef RC4_KEY_SEARCH_TIMEOUT_EN
    repeat (TO) tick();
    chk("hang.busy_at_limit", busy, 1'b1);
    chk("hang.fail_at_limit", fail, 1'b0);
    tick();
    chk("hang.fail", fail, 1'b1);
    chk("hang.timeout_err", timeout_err, 1'b1);
    chk("hang.busy_after", busy, 1'b0);
    go_req = 1'b1;
    tick();
    go_req = 1'b0;
    tick();
    chk("hang.go_clears_fail", fail, 1'b0);
    chk("hang.go_clears_timeout", timeout_err, 1'b0);
    chk("hang.restart_pulse", init_start, 1'b1);
    chk("hang.restart_key", key, KS);
`else
    repeat (40) tick();
    chk("hang.busy", busy, 1'b1);
    chk("hang.fail", fail, 1'b0);
    chk("hang.found", found, 1'b0);
    chk("hang.timeout_err", timeout_err, 1'b0);
    chk("hang.no_restart", n_start[1], 1);
`endif
    hang_dec = 1'b0;
    rst_req  = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    chk_reset_outputs("final_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
